mem_arbiter: RTL

Shares the multicycle core's single-port unified instruction/data memory between two requesters: the core's memory interface and a debug/loader port. It replaces the direct core-to-memory connection. It sequences each access through a small state machine, arbitrates round-robin, and returns read data to the owning requester with a valid pulse. A debug hold input lets the debugger lock the core out of memory while it loads programs or inspects data.

---
 rtl/mem_arbiter.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port unified instruction/data memory between the core's
// memory interface and a debug/loader port. Every access goes through
// IDLE -> ACCESS -> (WAIT -> RESP) and is granted round-robin. dbg_hold_i
// masks core requests at arbitration, so a debugger can lock the core out.
//
// Ports
//   clk_i, rst_ni                         clock (rising edge), async active-low reset
//   core_req_i/we_i/addr_i/wdata_i        core request, held until core_gnt_o
//   dbg_req_i/we_i/addr_i/wdata_i         debug request, held until dbg_gnt_o
//   dbg_hold_i                            1 = core requests ignored at arbitration
//   core_gnt_o, dbg_gnt_o                 one-cycle accept pulse (the memory cycle)
//   core_rvalid_o, dbg_rvalid_o           one-cycle read-data-valid pulse
//   core_rdata_o, dbg_rdata_o             read data, held until that port's next read
//   mem_en_o, mem_we_o, mem_addr_o,
//   mem_wdata_o, mem_rdata_i              single-port memory interface
//   busy_o                                arbiter is not IDLE
// All outputs are registered.
module mem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          core_req_i,
  input  logic          core_we_i,
  input  logic [AW-1:0] core_addr_i,
  input  logic [DW-1:0] core_wdata_i,
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [DW-1:0] dbg_wdata_i,
  input  logic          dbg_hold_i,
  output logic          core_gnt_o,
  output logic          dbg_gnt_o,
  output logic          core_rvalid_o,
  output logic          dbg_rvalid_o,
  output logic [DW-1:0] core_rdata_o,
  output logic [DW-1:0] dbg_rdata_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o
);

  localparam int unsigned CNT_W = 3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             last_dbg_q, last_dbg_d;   // 1 = debug port won the most recent grant
  logic             owner_q, owner_d;         // 1 = debug port owns the access in flight
  logic             we_q, we_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             core_gnt_q, core_gnt_d;
  logic             dbg_gnt_q, dbg_gnt_d;
  logic             core_rvalid_q, core_rvalid_d;
  logic             dbg_rvalid_q, dbg_rvalid_d;
  logic [DW-1:0]    core_rdata_q, core_rdata_d;
  logic [DW-1:0]    dbg_rdata_q, dbg_rdata_d;
  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
  logic             busy_q, busy_d;

  logic             core_eff_c;
  logic             any_req_c;
  logic             grant_dbg_c;

  // Arbitration: debug wins when alone, or on a tie when the core was granted last.
  always_comb begin
    core_eff_c  = core_req_i & ~dbg_hold_i;
    any_req_c   = core_eff_c | dbg_req_i;
    grant_dbg_c = dbg_req_i & (~core_eff_c | ~last_dbg_q);
  end

  // Next-state and next-output logic. Outputs are computed for the state being
  // entered so that, once registered, they line up with that state's cycle.
  always_comb begin
    state_d       = state_q;
    last_dbg_d    = last_dbg_q;
    owner_d       = owner_q;
    we_d          = we_q;
    cnt_d         = cnt_q;
    core_gnt_d    = 1'b0;
    dbg_gnt_d     = 1'b0;
    core_rvalid_d = 1'b0;
    dbg_rvalid_d  = 1'b0;
    core_rdata_d  = core_rdata_q;
    dbg_rdata_d   = dbg_rdata_q;
    mem_en_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;

    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (any_req_c) begin
          state_d     = ST_ACCESS;
          last_dbg_d  = grant_dbg_c;
          owner_d     = grant_dbg_c;
          we_d        = grant_dbg_c ? dbg_we_i    : core_we_i;
          core_gnt_d  = ~grant_dbg_c;
          dbg_gnt_d   = grant_dbg_c;
          mem_en_d    = 1'b1;
          mem_we_d    = grant_dbg_c ? dbg_we_i    : core_we_i;
          mem_addr_d  = grant_dbg_c ? dbg_addr_i  : core_addr_i;
          mem_wdata_d = grant_dbg_c ? dbg_wdata_i : core_wdata_i;
        end else begin
          state_d = ST_IDLE;
        end
      end

      // Requests are not sampled here, so a req still high in the gnt cycle
      // cannot be granted twice.
      ST_ACCESS: begin
        if (we_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(MEM_LAT);
        end
      end

      // Capture read data on the last wait cycle; it is presented with rvalid in RESP.
      ST_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_RESP;
          if (owner_q) begin
            dbg_rdata_d  = mem_rdata_i;
            dbg_rvalid_d = 1'b1;
          end else begin
            core_rdata_d  = mem_rdata_i;
            core_rvalid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers. Reset sets last_dbg so the core wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      last_dbg_q    <= 1'b1;
      owner_q       <= 1'b0;
      we_q          <= 1'b0;
      cnt_q         <= '0;
      core_gnt_q    <= 1'b0;
      dbg_gnt_q     <= 1'b0;
      core_rvalid_q <= 1'b0;
      dbg_rvalid_q  <= 1'b0;
      core_rdata_q  <= '0;
      dbg_rdata_q   <= '0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_dbg_q    <= last_dbg_d;
      owner_q       <= owner_d;
      we_q          <= we_d;
      cnt_q         <= cnt_d;
      core_gnt_q    <= core_gnt_d;
      dbg_gnt_q     <= dbg_gnt_d;
      core_rvalid_q <= core_rvalid_d;
      dbg_rvalid_q  <= dbg_rvalid_d;
      core_rdata_q  <= core_rdata_d;
      dbg_rdata_q   <= dbg_rdata_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      busy_q        <= busy_d;
    end
  end

  assign core_gnt_o    = core_gnt_q;
  assign dbg_gnt_o     = dbg_gnt_q;
  assign core_rvalid_o = core_rvalid_q;
  assign dbg_rvalid_o  = dbg_rvalid_q;
  assign core_rdata_o  = core_rdata_q;
  assign dbg_rdata_o   = dbg_rdata_q;
  assign mem_en_o      = mem_en_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign busy_o        = busy_q;

endmodule
